// File: rtl/dual_issue_decoder_pkg.sv
// Shared types for the SPU-lite dual-issue front end: opcodes, instruction
// formats, pipe selection, decode records and the prefix-matching lookup.
package dual_issue_decoder_pkg;

  typedef enum logic [4:0] {
    NO_OPERATION_EXECUTE,
    NO_OPERATION_LOAD,
    ADD_WORD,
    AND_WORD,
    SELECT_BITS,
    FLOATING_MULTIPLY_AND_ADD,
    ADD_HALFWORD_IMMEDIATE,
    IMMEDIATE_LOAD_WORD,
    IMMEDIATE_LOAD_ADDRESS,
    SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE,
    ROTATE_QUADWORD_BY_BYTES_IMMEDIATE,
    LOAD_QUADWORD_D,
    STORE_QUADWORD_D,
    BRANCH_RELATIVE
  } opcode_t;

  typedef enum logic [2:0] {RR, RRR, RI7, RI10, RI16, RI18} fmt_t;

  typedef enum logic {EVEN, ODD} pipe_t;

  typedef enum logic {PAIR, HOLD} state_t;

  typedef struct packed {
    opcode_t opcode;
    fmt_t    fmt;
    pipe_t   pipe;
    logic    writes_rt;
    logic    rt_is_source;
  } decode_t;

  typedef struct packed {
    logic [0:6]  ra;
    logic [0:6]  rb;
    logic [0:6]  rc;
    logic [0:6]  rt;
    logic [0:6]  i7;
    logic [0:9]  i10;
    logic [0:15] i16;
    logic [0:17] i18;
  } fields_t;

  // One issue slot: what a pipe sees for a cycle, or what the hold register keeps.
  typedef struct packed {
    opcode_t opcode;
    pipe_t   pipe;
    fields_t f;
  } slot_t;

  localparam decode_t DEC_NOP_EXECUTE = '{opcode: NO_OPERATION_EXECUTE, fmt: RR,
                                          pipe: EVEN, writes_rt: 1'b0,
                                          rt_is_source: 1'b0};

  localparam slot_t SLOT_NOP_E = '{opcode: NO_OPERATION_EXECUTE, pipe: EVEN, f: '0};
  localparam slot_t SLOT_NOP_L = '{opcode: NO_OPERATION_LOAD, pipe: ODD, f: '0};

  function automatic decode_t mk_dec(input opcode_t op, input fmt_t f, input pipe_t p,
                                     input logic wr, input logic src);
    decode_t d;
    d = '{opcode: op, fmt: f, pipe: p, writes_rt: wr, rt_is_source: src};
    return d;
  endfunction

  // Longest prefix wins: the 11-bit opcode space is tried first, then the
  // 9-, 8-, 7- and 4-bit spaces. Anything left over is an even-pipe nop.
  function automatic decode_t lookup(input logic [0:31] w);
    decode_t d;
    logic    hit;
    d   = DEC_NOP_EXECUTE;
    hit = 1'b1;
    case (w[0:10])
      11'b00011000000: d = mk_dec(ADD_WORD, RR, EVEN, 1'b1, 1'b0);
      11'b00011000001: d = mk_dec(AND_WORD, RR, EVEN, 1'b1, 1'b0);
      11'b00111111011: d = mk_dec(SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE, RI7, ODD, 1'b1, 1'b0);
      11'b00111111100: d = mk_dec(ROTATE_QUADWORD_BY_BYTES_IMMEDIATE, RI7, ODD, 1'b1, 1'b0);
      11'b01000000001: d = mk_dec(NO_OPERATION_EXECUTE, RR, EVEN, 1'b0, 1'b0);
      11'b00000000001: d = mk_dec(NO_OPERATION_LOAD, RR, ODD, 1'b0, 1'b0);
      default:         hit = 1'b0;
    endcase
    if (!hit) begin
      hit = 1'b1;
      case (w[0:8])
        9'b010000001: d = mk_dec(IMMEDIATE_LOAD_WORD, RI16, EVEN, 1'b1, 1'b0);
        9'b001100100: d = mk_dec(BRANCH_RELATIVE, RI16, ODD, 1'b0, 1'b0);
        default:      hit = 1'b0;
      endcase
    end
    if (!hit) begin
      hit = 1'b1;
      case (w[0:7])
        8'b00011101: d = mk_dec(ADD_HALFWORD_IMMEDIATE, RI10, EVEN, 1'b1, 1'b0);
        8'b00110100: d = mk_dec(LOAD_QUADWORD_D, RI10, ODD, 1'b1, 1'b0);
        8'b00100100: d = mk_dec(STORE_QUADWORD_D, RI10, ODD, 1'b0, 1'b1);
        default:     hit = 1'b0;
      endcase
    end
    if (!hit) begin
      hit = 1'b1;
      case (w[0:6])
        7'b0100001: d = mk_dec(IMMEDIATE_LOAD_ADDRESS, RI18, EVEN, 1'b1, 1'b0);
        default:    hit = 1'b0;
      endcase
    end
    if (!hit) begin
      case (w[0:3])
        4'b1000: d = mk_dec(SELECT_BITS, RRR, EVEN, 1'b1, 1'b0);
        4'b1110: d = mk_dec(FLOATING_MULTIPLY_AND_ADD, RRR, EVEN, 1'b1, 1'b0);
        default: d = DEC_NOP_EXECUTE;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/spu_word_decode.sv
// Combinational decode of one instruction word: classification, field
// extraction by format, and which register fields the word reads.
module spu_word_decode
  import dual_issue_decoder_pkg::*;
(
  input  logic [0:31] word_i,
  output decode_t     dec_o,
  output fields_t     fields_o,
  output logic        reads_ra_o,
  output logic        reads_rb_o,
  output logic        reads_rc_o,
  output logic        reads_rt_o
);

  decode_t dec;
  fields_t fields;
  logic    rd_ra, rd_rb, rd_rc, rd_rt;

  // Classify, then pull out only the fields the format defines.
  always_comb begin
    dec    = lookup(word_i);
    fields = '0;
    rd_ra  = 1'b0;
    rd_rb  = 1'b0;
    rd_rc  = 1'b0;
    rd_rt  = dec.rt_is_source;
    case (dec.fmt)
      RR: begin
        fields.rb = word_i[11:17];
        fields.ra = word_i[18:24];
        fields.rt = word_i[25:31];
        rd_ra     = 1'b1;
        rd_rb     = 1'b1;
      end
      RRR: begin
        fields.rt = word_i[4:10];
        fields.rb = word_i[11:17];
        fields.ra = word_i[18:24];
        fields.rc = word_i[25:31];
        rd_ra     = 1'b1;
        rd_rb     = 1'b1;
        rd_rc     = 1'b1;
      end
      RI7: begin
        fields.i7 = word_i[11:17];
        fields.ra = word_i[18:24];
        fields.rt = word_i[25:31];
        rd_ra     = 1'b1;
      end
      RI10: begin
        fields.i10 = word_i[8:17];
        fields.ra  = word_i[18:24];
        fields.rt  = word_i[25:31];
        rd_ra      = 1'b1;
      end
      RI16: begin
        fields.i16 = word_i[9:24];
        fields.rt  = word_i[25:31];
      end
      RI18: begin
        fields.i18 = word_i[7:24];
        fields.rt  = word_i[25:31];
      end
      default: fields = '0;
    endcase
    // Nops (including unrecognised words) carry no operands, so they can never
    // create a false RAW dependency or leak garbage onto the issue fields.
    if (dec.opcode == NO_OPERATION_EXECUTE || dec.opcode == NO_OPERATION_LOAD) begin
      fields = '0;
      rd_ra  = 1'b0;
      rd_rb  = 1'b0;
      rd_rc  = 1'b0;
      rd_rt  = 1'b0;
    end
  end

  assign dec_o      = dec;
  assign fields_o   = fields;
  assign reads_ra_o = rd_ra;
  assign reads_rb_o = rd_rb;
  assign reads_rc_o = rd_rc;
  assign reads_rt_o = rd_rt;

endmodule

// File: rtl/dual_issue_decoder.sv
// Dual-issue front end: decodes an instruction pair, steers each word to the
// even or odd pipe, and splits the pair over two cycles on a conflict.
//
//   state | meaning
//   PAIR  | accepting pairs; issues both words, or the older one on a conflict
//   HOLD  | younger word parked in the hold register; issue it, accept nothing
module dual_issue_decoder
  import dual_issue_decoder_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     instr_valid,
  input  logic [0:2*INSTR_WIDTH-1] instr_pair,
  input  logic [0:PC_WIDTH-1]      PC_in,
  input  logic                     stall_in,
  input  logic                     branch_taken,
  output logic                     instr_ready,
  output opcode_t                  ep_opcode,
  output logic [0:6]               ra_ep_address,
  output logic [0:6]               rb_ep_address,
  output logic [0:6]               rc_ep_address,
  output logic [0:6]               rt_ep_address,
  output logic [0:6]               I7_ep,
  output logic [0:9]               I10_ep,
  output logic [0:15]              I16_ep,
  output logic [0:17]              I18_ep,
  output opcode_t                  op_opcode,
  output logic [0:6]               ra_op_address,
  output logic [0:6]               rb_op_address,
  output logic [0:6]               rt_op_address,
  output logic [0:6]               I7_op,
  output logic [0:9]               I10_op,
  output logic [0:15]              I16_op,
  output logic [0:17]              I18_op,
  output logic [0:PC_WIDTH-1]      PC_output
);

  logic [0:INSTR_WIDTH-1] word_a, word_b;
  decode_t dec_a, dec_b;
  fields_t fields_a, fields_b;
  logic    a_reads_ra, a_reads_rb, a_reads_rc, a_reads_rt;
  logic    b_reads_ra, b_reads_rb, b_reads_rc, b_reads_rt;

  assign word_a = instr_pair[0:INSTR_WIDTH-1];
  assign word_b = instr_pair[INSTR_WIDTH:2*INSTR_WIDTH-1];

  spu_word_decode u_dec_a (
    .word_i     (word_a),
    .dec_o      (dec_a),
    .fields_o   (fields_a),
    .reads_ra_o (a_reads_ra),
    .reads_rb_o (a_reads_rb),
    .reads_rc_o (a_reads_rc),
    .reads_rt_o (a_reads_rt)
  );

  spu_word_decode u_dec_b (
    .word_i     (word_b),
    .dec_o      (dec_b),
    .fields_o   (fields_b),
    .reads_ra_o (b_reads_ra),
    .reads_rb_o (b_reads_rb),
    .reads_rc_o (b_reads_rc),
    .reads_rt_o (b_reads_rt)
  );

  slot_t slot_a, slot_b;
  logic  raw_hazard, conflict;

  assign slot_a = '{opcode: dec_a.opcode, pipe: dec_a.pipe, f: fields_a};
  assign slot_b = '{opcode: dec_b.opcode, pipe: dec_b.pipe, f: fields_b};

  // B depends on A if any register B actually reads is the one A writes.
  assign raw_hazard = dec_a.writes_rt &&
                      ((b_reads_ra && (fields_b.ra == fields_a.rt)) ||
                       (b_reads_rb && (fields_b.rb == fields_a.rt)) ||
                       (b_reads_rc && (fields_b.rc == fields_a.rt)) ||
                       (b_reads_rt && (fields_b.rt == fields_a.rt)));
  assign conflict   = (dec_a.pipe == dec_b.pipe) || raw_hazard;

  state_t               state_q, state_d;
  slot_t                ep_q, ep_d, op_q, op_d;
  slot_t                hold_q, hold_d;
  logic [0:PC_WIDTH-1]  hold_pc_q, hold_pc_d;
  logic [0:PC_WIDTH-1]  pc_q, pc_d;

  // Pairing decisions: flush beats stall, stall beats everything else.
  always_comb begin
    state_d   = state_q;
    ep_d      = ep_q;
    op_d      = op_q;
    hold_d    = hold_q;
    hold_pc_d = hold_pc_q;
    pc_d      = pc_q;
    if (branch_taken) begin
      ep_d      = SLOT_NOP_E;
      op_d      = SLOT_NOP_L;
      hold_d    = SLOT_NOP_E;
      hold_pc_d = '0;
      state_d   = PAIR;
    end else if (stall_in) begin
      state_d = state_q;
    end else if (state_q == HOLD) begin
      ep_d = SLOT_NOP_E;
      op_d = SLOT_NOP_L;
      if (hold_q.pipe == EVEN) ep_d = hold_q;
      else                     op_d = hold_q;
      pc_d      = hold_pc_q;
      hold_d    = SLOT_NOP_E;
      hold_pc_d = '0;
      state_d   = PAIR;
    end else if (instr_valid) begin
      ep_d = SLOT_NOP_E;
      op_d = SLOT_NOP_L;
      if (slot_a.pipe == EVEN) ep_d = slot_a;
      else                     op_d = slot_a;
      pc_d = PC_in;
      if (conflict) begin
        hold_d    = slot_b;
        hold_pc_d = PC_in + PC_WIDTH'(4);
        state_d   = HOLD;
      end else begin
        if (slot_b.pipe == EVEN) ep_d = slot_b;
        else                     op_d = slot_b;
      end
    end else begin
      ep_d = SLOT_NOP_E;
      op_d = SLOT_NOP_L;
    end
  end

  // State, hold and issue registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= PAIR;
      ep_q      <= SLOT_NOP_E;
      op_q      <= SLOT_NOP_L;
      hold_q    <= SLOT_NOP_E;
      hold_pc_q <= '0;
      pc_q      <= '0;
    end else begin
      state_q   <= state_d;
      ep_q      <= ep_d;
      op_q      <= op_d;
      hold_q    <= hold_d;
      hold_pc_q <= hold_pc_d;
      pc_q      <= pc_d;
    end
  end

  // Ready is a decode of the registered state, gated by this cycle's stall and
  // flush so that a pair is never consumed while either is asserted.
  assign instr_ready = (state_q == PAIR) && !stall_in && !branch_taken;

  assign ep_opcode     = ep_q.opcode;
  assign ra_ep_address = ep_q.f.ra;
  assign rb_ep_address = ep_q.f.rb;
  assign rc_ep_address = ep_q.f.rc;
  assign rt_ep_address = ep_q.f.rt;
  assign I7_ep         = ep_q.f.i7;
  assign I10_ep        = ep_q.f.i10;
  assign I16_ep        = ep_q.f.i16;
  assign I18_ep        = ep_q.f.i18;

  assign op_opcode     = op_q.opcode;
  assign ra_op_address = op_q.f.ra;
  assign rb_op_address = op_q.f.rb;
  assign rt_op_address = op_q.f.rt;
  assign I7_op         = op_q.f.i7;
  assign I10_op        = op_q.f.i10;
  assign I16_op        = op_q.f.i16;
  assign I18_op        = op_q.f.i18;

  assign PC_output = pc_q;

  // The odd pipe has no rc port and A's source set never matters to pairing.
  logic unused_bits;
  assign unused_bits = ^{ep_q.pipe, op_q.pipe, op_q.f.rc, dec_a.fmt, dec_a.rt_is_source,
                         dec_b.fmt, dec_b.writes_rt, a_reads_ra, a_reads_rb,
                         a_reads_rc, a_reads_rt};

endmodule

// File: tb/tb_dual_issue_decoder.sv
// Directed bench for dual_issue_decoder: reset, clean pairs, structural and
// RAW splits, flush, stall, unmatched words and reset during HOLD.
module tb_dual_issue_decoder;
  import dual_issue_decoder_pkg::*;

  logic         clock, reset, instr_valid, stall_in, branch_taken;
  logic [0:63]  instr_pair;
  logic [0:31]  PC_in;
  logic         instr_ready;
  opcode_t      ep_opcode, op_opcode;
  logic [0:6]   ra_ep_address, rb_ep_address, rc_ep_address, rt_ep_address;
  logic [0:6]   ra_op_address, rb_op_address, rt_op_address;
  logic [0:6]   I7_ep, I7_op;
  logic [0:9]   I10_ep, I10_op;
  logic [0:15]  I16_ep, I16_op;
  logic [0:17]  I18_ep, I18_op;
  logic [0:31]  PC_output;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] W_A_16_1_3    = 32'h1800C090; // a $16,$1,$3
  localparam logic [31:0] W_SHLQBII     = 32'h3F614111; // shlqbii $17,$2,5
  localparam logic [31:0] W_IL_1_2      = 32'h40800101; // il $1,2
  localparam logic [31:0] W_AHI_18_1_5  = 32'h1D014092; // ahi $18,$1,5
  localparam logic [31:0] W_ROTQBYI     = 32'h3F810817; // rotqbyi $23,$16,4
  localparam logic [31:0] W_STQD_16     = 32'h24000290; // stqd $16,0($5)
  localparam logic [31:0] W_STQD_17     = 32'h24000291; // stqd $17,0($5)

  dual_issue_decoder dut (
    .clock         (clock),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr_pair    (instr_pair),
    .PC_in         (PC_in),
    .stall_in      (stall_in),
    .branch_taken  (branch_taken),
    .instr_ready   (instr_ready),
    .ep_opcode     (ep_opcode),
    .ra_ep_address (ra_ep_address),
    .rb_ep_address (rb_ep_address),
    .rc_ep_address (rc_ep_address),
    .rt_ep_address (rt_ep_address),
    .I7_ep         (I7_ep),
    .I10_ep        (I10_ep),
    .I16_ep        (I16_ep),
    .I18_ep        (I18_ep),
    .op_opcode     (op_opcode),
    .ra_op_address (ra_op_address),
    .rb_op_address (rb_op_address),
    .rt_op_address (rt_op_address),
    .I7_op         (I7_op),
    .I10_op        (I10_op),
    .I16_op        (I16_op),
    .I18_op        (I18_op),
    .PC_output     (PC_output)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
    instr_pair  = {a, b};
    PC_in       = pc;
    instr_valid = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; instr_valid = 1'b0; stall_in = 1'b0; branch_taken = 1'b0;
    instr_pair = '0; PC_in = '0;
    tick; tick;
    reset = 1'b1;
    #1;
    total++; if (ep_opcode !== NO_OPERATION_EXECUTE) begin bad++; $display("FAIL reset_ep_opcode got=%0d exp=%0d", ep_opcode, NO_OPERATION_EXECUTE); end
    total++; if (op_opcode !== NO_OPERATION_LOAD) begin bad++; $display("FAIL reset_op_opcode got=%0d exp=%0d", op_opcode, NO_OPERATION_LOAD); end
    total++; if ({ra_ep_address, rb_ep_address, rc_ep_address, rt_ep_address, I7_ep, I10_ep, I16_ep, I18_ep} !== '0) begin bad++; $display("FAIL reset_ep_fields got=nonzero exp=0"); end
    total++; if ({ra_op_address, rb_op_address, rt_op_address, I7_op, I10_op, I16_op, I18_op} !== '0) begin bad++; $display("FAIL reset_op_fields got=nonzero exp=0"); end
    total++; if (PC_output !== 32'h0) begin bad++; $display("FAIL reset_pc got=%0h exp=0", PC_output); end
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", instr_ready); end
  endtask

  task automatic test_clean_pair;
    present(W_A_16_1_3, W_SHLQBII, 32'h40);
    tick;
    instr_valid = 1'b0;
    total++; if (ep_opcode !== ADD_WORD) begin bad++; $display("FAIL clean_ep_opcode got=%0d exp=%0d", ep_opcode, ADD_WORD); end
    total++; if ({ra_ep_address, rb_ep_address, rt_ep_address, rc_ep_address} !== {7'd1, 7'd3, 7'd16, 7'd0}) begin bad++; $display("FAIL clean_ep_regs got=%0d/%0d/%0d/%0d exp=1/3/16/0", ra_ep_address, rb_ep_address, rt_ep_address, rc_ep_address); end
    total++; if (op_opcode !== SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE) begin bad++; $display("FAIL clean_op_opcode got=%0d exp=%0d", op_opcode, SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE); end
    total++; if ({ra_op_address, I7_op, rt_op_address} !== {7'd2, 7'd5, 7'd17}) begin bad++; $display("FAIL clean_op_fields got=%0d/%0d/%0d exp=2/5/17", ra_op_address, I7_op, rt_op_address); end
    total++; if (PC_output !== 32'h40) begin bad++; $display("FAIL clean_pc got=%0h exp=40", PC_output); end
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL clean_ready got=%0b exp=1", instr_ready); end
  endtask

  task automatic test_empty_cycle;
    tick;
    total++; if (ep_opcode !== NO_OPERATION_EXECUTE || op_opcode !== NO_OPERATION_LOAD) begin bad++; $display("FAIL empty_nops got=%0d/%0d exp=%0d/%0d", ep_opcode, op_opcode, NO_OPERATION_EXECUTE, NO_OPERATION_LOAD); end
    total++; if (PC_output !== 32'h40) begin bad++; $display("FAIL empty_pc_hold got=%0h exp=40", PC_output); end
  endtask

  task automatic test_structural_split;
    present(W_IL_1_2, W_AHI_18_1_5, 32'h80);
    tick;
    instr_valid = 1'b0;
    total++; if (ep_opcode !== IMMEDIATE_LOAD_WORD) begin bad++; $display("FAIL struct_c1_opcode got=%0d exp=%0d", ep_opcode, IMMEDIATE_LOAD_WORD); end
    total++; if ({I16_ep, rt_ep_address} !== {16'd2, 7'd1}) begin bad++; $display("FAIL struct_c1_fields got=%0d/%0d exp=2/1", I16_ep, rt_ep_address); end
    total++; if (op_opcode !== NO_OPERATION_LOAD) begin bad++; $display("FAIL struct_c1_op_nop got=%0d exp=%0d", op_opcode, NO_OPERATION_LOAD); end
    total++; if (PC_output !== 32'h80) begin bad++; $display("FAIL struct_c1_pc got=%0h exp=80", PC_output); end
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL struct_c1_ready got=%0b exp=0", instr_ready); end
    tick;
    total++; if (ep_opcode !== ADD_HALFWORD_IMMEDIATE) begin bad++; $display("FAIL struct_c2_opcode got=%0d exp=%0d", ep_opcode, ADD_HALFWORD_IMMEDIATE); end
    total++; if ({I10_ep, ra_ep_address, rt_ep_address, I16_ep} !== {10'd5, 7'd1, 7'd18, 16'd0}) begin bad++; $display("FAIL struct_c2_fields got=%0d/%0d/%0d/%0d exp=5/1/18/0", I10_ep, ra_ep_address, rt_ep_address, I16_ep); end
    total++; if (PC_output !== 32'h84) begin bad++; $display("FAIL struct_c2_pc got=%0h exp=84", PC_output); end
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL struct_c2_ready got=%0b exp=1", instr_ready); end
  endtask

  task automatic test_raw_split;
    present(W_A_16_1_3, W_ROTQBYI, 32'h100);
    tick;
    instr_valid = 1'b0;
    total++; if (ep_opcode !== ADD_WORD || op_opcode !== NO_OPERATION_LOAD) begin bad++; $display("FAIL raw_c1_opcodes got=%0d/%0d exp=%0d/%0d", ep_opcode, op_opcode, ADD_WORD, NO_OPERATION_LOAD); end
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL raw_c1_ready got=%0b exp=0", instr_ready); end
    tick;
    total++; if (op_opcode !== ROTATE_QUADWORD_BY_BYTES_IMMEDIATE || ep_opcode !== NO_OPERATION_EXECUTE) begin bad++; $display("FAIL raw_c2_opcodes got=%0d/%0d exp=%0d/%0d", op_opcode, ep_opcode, ROTATE_QUADWORD_BY_BYTES_IMMEDIATE, NO_OPERATION_EXECUTE); end
    total++; if ({ra_op_address, I7_op, rt_op_address} !== {7'd16, 7'd4, 7'd23}) begin bad++; $display("FAIL raw_c2_fields got=%0d/%0d/%0d exp=16/4/23", ra_op_address, I7_op, rt_op_address); end
    total++; if (PC_output !== 32'h104) begin bad++; $display("FAIL raw_c2_pc got=%0h exp=104", PC_output); end
  endtask

  task automatic test_store_source;
    present(W_A_16_1_3, W_STQD_16, 32'h140);
    tick;
    instr_valid = 1'b0;
    total++; if (op_opcode !== NO_OPERATION_LOAD || instr_ready !== 1'b0) begin bad++; $display("FAIL stq_dep_c1 got=%0d/%0b exp=%0d/0", op_opcode, instr_ready, NO_OPERATION_LOAD); end
    tick;
    total++; if (op_opcode !== STORE_QUADWORD_D || {rt_op_address, ra_op_address} !== {7'd16, 7'd5}) begin bad++; $display("FAIL stq_dep_c2 got=%0d/%0d/%0d exp=%0d/16/5", op_opcode, rt_op_address, ra_op_address, STORE_QUADWORD_D); end
    present(W_A_16_1_3, W_STQD_17, 32'h180);
    tick;
    instr_valid = 1'b0;
    total++; if (ep_opcode !== ADD_WORD || op_opcode !== STORE_QUADWORD_D || rt_op_address !== 7'd17) begin bad++; $display("FAIL stq_indep got=%0d/%0d/%0d exp=%0d/%0d/17", ep_opcode, op_opcode, rt_op_address, ADD_WORD, STORE_QUADWORD_D); end
    total++; if (PC_output !== 32'h180 || instr_ready !== 1'b1) begin bad++; $display("FAIL stq_indep_pc got=%0h/%0b exp=180/1", PC_output, instr_ready); end
  endtask

  task automatic test_flush_in_hold;
    present(W_IL_1_2, W_AHI_18_1_5, 32'h200);
    tick;
    instr_valid = 1'b0;
    total++; if (ep_opcode !== IMMEDIATE_LOAD_WORD) begin bad++; $display("FAIL flushh_c1 got=%0d exp=%0d", ep_opcode, IMMEDIATE_LOAD_WORD); end
    branch_taken = 1'b1;
    tick;
    branch_taken = 1'b0;
    #1;
    total++; if (ep_opcode !== NO_OPERATION_EXECUTE || op_opcode !== NO_OPERATION_LOAD) begin bad++; $display("FAIL flushh_nops got=%0d/%0d exp=%0d/%0d", ep_opcode, op_opcode, NO_OPERATION_EXECUTE, NO_OPERATION_LOAD); end
    total++; if (I10_ep !== 10'd0 || instr_ready !== 1'b1) begin bad++; $display("FAIL flushh_state got=%0d/%0b exp=0/1", I10_ep, instr_ready); end
    tick;
    total++; if (ep_opcode !== NO_OPERATION_EXECUTE || PC_output !== 32'h200) begin bad++; $display("FAIL flushh_b_dropped got=%0d/%0h exp=%0d/200", ep_opcode, PC_output, NO_OPERATION_EXECUTE); end
  endtask

  task automatic test_flush_with_pair;
    present(W_A_16_1_3, W_SHLQBII, 32'h500);
    branch_taken = 1'b1;
    #1;
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL flushp_ready got=%0b exp=0", instr_ready); end
    tick;
    branch_taken = 1'b0;
    instr_valid  = 1'b0;
    total++; if (ep_opcode !== NO_OPERATION_EXECUTE || op_opcode !== NO_OPERATION_LOAD || PC_output !== 32'h200) begin bad++; $display("FAIL flushp_not_consumed got=%0d/%0d/%0h exp=%0d/%0d/200", ep_opcode, op_opcode, PC_output, NO_OPERATION_EXECUTE, NO_OPERATION_LOAD); end
  endtask

  task automatic test_stall;
    present(W_A_16_1_3, W_SHLQBII, 32'h300);
    tick;
    stall_in = 1'b1;
    present(W_IL_1_2, W_SHLQBII, 32'h400);
    #1;
    total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%0b exp=0", instr_ready); end
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (ep_opcode !== ADD_WORD || op_opcode !== SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE || PC_output !== 32'h300 || rt_ep_address !== 7'd16) begin bad++; $display("FAIL stall_hold_%0d got=%0d/%0d/%0h exp=%0d/%0d/300", i, ep_opcode, op_opcode, PC_output, ADD_WORD, SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE); end
      total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL stall_ready_%0d got=%0b exp=0", i, instr_ready); end
    end
    stall_in = 1'b0;
    #1;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%0b exp=1", instr_ready); end
    tick;
    instr_valid = 1'b0;
    total++; if (ep_opcode !== IMMEDIATE_LOAD_WORD || I16_ep !== 16'd2 || PC_output !== 32'h400) begin bad++; $display("FAIL stall_next_pair got=%0d/%0d/%0h exp=%0d/2/400", ep_opcode, I16_ep, PC_output, IMMEDIATE_LOAD_WORD); end
  endtask

  task automatic test_unmatched;
    present(32'hFFFFFFFF, W_SHLQBII, 32'h600);
    tick;
    instr_valid = 1'b0;
    total++; if (ep_opcode !== NO_OPERATION_EXECUTE || op_opcode !== SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE) begin bad++; $display("FAIL unmatched_opcodes got=%0d/%0d exp=%0d/%0d", ep_opcode, op_opcode, NO_OPERATION_EXECUTE, SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE); end
    total++; if ({ra_ep_address, rb_ep_address, rc_ep_address, rt_ep_address, I7_ep, I10_ep, I16_ep, I18_ep} !== '0) begin bad++; $display("FAIL unmatched_fields got=nonzero exp=0"); end
    total++; if (PC_output !== 32'h600 || instr_ready !== 1'b1) begin bad++; $display("FAIL unmatched_pc got=%0h/%0b exp=600/1", PC_output, instr_ready); end
  endtask

  task automatic test_reset_mid_hold;
    present(W_IL_1_2, W_AHI_18_1_5, 32'h700);
    tick;
    instr_valid = 1'b0;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    #1;
    total++; if (ep_opcode !== NO_OPERATION_EXECUTE || PC_output !== 32'h0 || instr_ready !== 1'b1) begin bad++; $display("FAIL rsthold_c1 got=%0d/%0h/%0b exp=%0d/0/1", ep_opcode, PC_output, instr_ready, NO_OPERATION_EXECUTE); end
    tick;
    total++; if (ep_opcode !== NO_OPERATION_EXECUTE || I10_ep !== 10'd0) begin bad++; $display("FAIL rsthold_b_dropped got=%0d/%0d exp=%0d/0", ep_opcode, I10_ep, NO_OPERATION_EXECUTE); end
  endtask

  initial begin
    test_reset;
    test_clean_pair;
    test_empty_cycle;
    test_structural_split;
    test_raw_split;
    test_store_source;
    test_flush_in_hold;
    test_flush_with_pair;
    test_stall;
    test_unmatched;
    test_reset_mid_hold;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
